// File: rtl/sb_rx_deser.sv
// Sideband receive deserializer: rebuilds LSB-first 64-bit words from the serial pin and queues them in a small FIFO.
// Define SB_RX_ERR_CNT_EN to build the saturating framing-error and dropped-frame counters.
module sb_rx_deser #(
    parameter int BUFFER_SIZE = 4,
    parameter int MIN_GAP     = 32
) (
    input  logic        clk_800MHz,
    input  logic        reset_n,
    input  logic        dataPin_i,
    input  logic        clkValid_i,
    input  logic        enable_i,
    output logic [63:0] data_o,
    output logic        valid_o,
    input  logic        ready_i,
    output logic        overflow_o,
    output logic        frame_err_o,
    output logic [7:0]  frame_err_cnt_o,
    output logic [7:0]  overflow_cnt_o
);

    localparam int PTR_W = $clog2(BUFFER_SIZE);
    localparam int CNT_W = PTR_W + 1;
    localparam int GAP_W = $clog2(MIN_GAP + 1);
    localparam logic [GAP_W-1:0] GAP_LIMIT = GAP_W'(MIN_GAP);
    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(BUFFER_SIZE);

    typedef enum logic [1:0] {IDLE, RECEIVING, GAP, RESYNC} state_t;

    state_t            state_q, state_d;
    logic [5:0]        bitCtr_q, bitCtr_d;
    logic [GAP_W-1:0]  gapCtr_q, gapCtr_d, gapInc;
    logic [63:0]       shift_q, shift_d;
    logic              wordDone;
    logic              frameErr_q, frameErr_d;

    logic [63:0]       mem_q [BUFFER_SIZE];
    logic [PTR_W-1:0]  wrPtr_q, rdPtr_q;
    logic [CNT_W-1:0]  count_q;
    logic              overflow_q;
    logic              full, push, pop, drop;

    always_ff @(posedge clk_800MHz) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            bitCtr_q   <= '0;
            gapCtr_q   <= '0;
            shift_q    <= '0;
            frameErr_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            bitCtr_q   <= bitCtr_d;
            gapCtr_q   <= gapCtr_d;
            shift_q    <= shift_d;
            frameErr_q <= frameErr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        bitCtr_d   = bitCtr_q;
        gapCtr_d   = gapCtr_q;
        shift_d    = shift_q;
        wordDone   = 1'b0;
        frameErr_d = 1'b0;
        gapInc     = gapCtr_q + GAP_W'(1);
        case (state_q)
            IDLE: begin
                if (clkValid_i) begin
                    shift_d[0] = dataPin_i;
                    bitCtr_d   = 6'd1;
                    state_d    = RECEIVING;
                end
            end
            RECEIVING: begin
                if (clkValid_i) begin
                    shift_d[bitCtr_q] = dataPin_i;
                    bitCtr_d          = bitCtr_q + 6'd1;
                    if (bitCtr_q == 6'd63) begin
                        wordDone = 1'b1;
                        gapCtr_d = '0;
                        state_d  = GAP;
                    end
                end else begin
                    frameErr_d = 1'b1;
                    bitCtr_d   = '0;
                    gapCtr_d   = '0;
                    state_d    = RESYNC;
                end
            end
            GAP: begin
                if (clkValid_i) begin
                    frameErr_d = 1'b1;
                    gapCtr_d   = '0;
                    state_d    = RESYNC;
                end else if (gapInc == GAP_LIMIT) begin
                    gapCtr_d = '0;
                    state_d  = IDLE;
                end else begin
                    gapCtr_d = gapInc;
                end
            end
            RESYNC: begin
                // Any toggling restarts the quiet-time count; the link must be idle MIN_GAP cycles in a row.
                if (clkValid_i) begin
                    gapCtr_d = '0;
                end else if (gapInc == GAP_LIMIT) begin
                    gapCtr_d = '0;
                    state_d  = IDLE;
                end else begin
                    gapCtr_d = gapInc;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign valid_o = (count_q != '0);
    assign full    = (count_q == FULL_CNT);
    assign pop     = valid_o && ready_i;
    // A pop on the capture edge frees a slot, so a full FIFO can still take the new word.
    assign push    = wordDone && enable_i && (!full || pop);
    assign drop    = wordDone && enable_i && full && !pop;

    always_ff @(posedge clk_800MHz) begin
        if (!reset_n) begin
            for (int i = 0; i < BUFFER_SIZE; i++) mem_q[i] <= '0;
            wrPtr_q    <= '0;
            rdPtr_q    <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push) begin
                mem_q[wrPtr_q] <= shift_d;
                wrPtr_q        <= wrPtr_q + PTR_W'(1);
            end
            if (pop) rdPtr_q <= rdPtr_q + PTR_W'(1);
            if (push && !pop)      count_q <= count_q + CNT_W'(1);
            else if (pop && !push) count_q <= count_q - CNT_W'(1);
            if (drop) overflow_q <= 1'b1;
        end
    end

    assign data_o      = mem_q[rdPtr_q];
    assign overflow_o  = overflow_q;
    assign frame_err_o = frameErr_q;

`ifdef SB_RX_ERR_CNT_EN
    logic [7:0] frameErrCnt_q, overflowCnt_q;

    always_ff @(posedge clk_800MHz) begin
        if (!reset_n) begin
            frameErrCnt_q <= '0;
            overflowCnt_q <= '0;
        end else begin
            if (frameErr_d && frameErrCnt_q != 8'hFF) frameErrCnt_q <= frameErrCnt_q + 8'd1;
            if (drop && overflowCnt_q != 8'hFF)       overflowCnt_q <= overflowCnt_q + 8'd1;
        end
    end

    assign frame_err_cnt_o = frameErrCnt_q;
    assign overflow_cnt_o  = overflowCnt_q;
`else
    assign frame_err_cnt_o = 8'd0;
    assign overflow_cnt_o  = 8'd0;
`endif

endmodule

// File: tb/tb_sb_rx_deser.sv
// Directed self-checking bench for sb_rx_deser; inputs change and outputs are sampled on the falling edge.
// Counter expectations follow SB_RX_ERR_CNT_EN as defined for the build.
`timescale 1ns/1ps
module tb_sb_rx_deser;

    logic        clk_800MHz = 1'b0;
    logic        reset_n    = 1'b0;
    logic        dataPin_i  = 1'b0;
    logic        clkValid_i = 1'b0;
    logic        enable_i   = 1'b1;
    logic        ready_i    = 1'b0;
    logic [63:0] data_o;
    logic        valid_o;
    logic        overflow_o;
    logic        frame_err_o;
    logic [7:0]  frame_err_cnt_o;
    logic [7:0]  overflow_cnt_o;

    int assertCount = 0;
    int failCount   = 0;

`ifdef SB_RX_ERR_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    always #0.625 clk_800MHz = ~clk_800MHz;

    sb_rx_deser #(.BUFFER_SIZE(4), .MIN_GAP(32)) dut (
        .clk_800MHz      (clk_800MHz),
        .reset_n         (reset_n),
        .dataPin_i       (dataPin_i),
        .clkValid_i      (clkValid_i),
        .enable_i        (enable_i),
        .data_o          (data_o),
        .valid_o         (valid_o),
        .ready_i         (ready_i),
        .overflow_o      (overflow_o),
        .frame_err_o     (frame_err_o),
        .frame_err_cnt_o (frame_err_cnt_o),
        .overflow_cnt_o  (overflow_cnt_o)
    );

    // Drive bits lo..hi of a word, one per cycle, with the bit-valid qualifier high.
    task automatic applyStimulus(input logic [63:0] word, input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            @(negedge clk_800MHz);
            clkValid_i = 1'b1;
            dataPin_i  = word[i];
        end
    endtask

    // Idle cycles toggle the data pin so that ignoring it without clkValid_i is exercised.
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk_800MHz);
            clkValid_i = 1'b0;
            dataPin_i  = ~dataPin_i;
        end
    endtask

    task automatic doReset();
        @(negedge clk_800MHz);
        reset_n    = 1'b0;
        clkValid_i = 1'b0;
        dataPin_i  = 1'b0;
        ready_i    = 1'b0;
        enable_i   = 1'b1;
        @(negedge clk_800MHz);
        @(negedge clk_800MHz);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        doReset();
        assertCount++; if (valid_o !== 1'b0) begin failCount++; $display("[TB] FAIL reset_valid: got %b expected 0", valid_o); end
        assertCount++; if (data_o !== 64'd0) begin failCount++; $display("[TB] FAIL reset_data: got %h expected 0", data_o); end
        assertCount++; if (overflow_o !== 1'b0) begin failCount++; $display("[TB] FAIL reset_overflow: got %b expected 0", overflow_o); end
        assertCount++; if (frame_err_o !== 1'b0) begin failCount++; $display("[TB] FAIL reset_frame_err: got %b expected 0", frame_err_o); end
        assertCount++; if (frame_err_cnt_o !== 8'd0) begin failCount++; $display("[TB] FAIL reset_err_cnt: got %0d expected 0", frame_err_cnt_o); end
        assertCount++; if (overflow_cnt_o !== 8'd0) begin failCount++; $display("[TB] FAIL reset_ovf_cnt: got %0d expected 0", overflow_cnt_o); end
    endtask

    task automatic test_single_frame();
        logic [63:0] w;
        w = 64'hDEADBEEF_0123ABCD;
        doReset();
        ready_i = 1'b1;
        applyStimulus(w, 0, 62);
        assertCount++; if (valid_o !== 1'b0) begin failCount++; $display("[TB] FAIL single_early_valid: got %b expected 0", valid_o); end
        applyStimulus(w, 63, 63);
        idle(1);
        assertCount++; if (valid_o !== 1'b1) begin failCount++; $display("[TB] FAIL single_valid: got %b expected 1", valid_o); end
        assertCount++; if (data_o !== w) begin failCount++; $display("[TB] FAIL single_data: got %h expected %h", data_o, w); end
        idle(1);
        assertCount++; if (valid_o !== 1'b0) begin failCount++; $display("[TB] FAIL single_valid_pulse: got %b expected 0", valid_o); end
        ready_i = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [63:0] w [6];
        w = '{64'h1111_2222_3333_4444, 64'h8000_0000_0000_0001, 64'hFFFF_0000_FFFF_0000,
              64'h0123_4567_89AB_CDEF, 64'hAAAA_5555_AAAA_5555, 64'hCAFE_F00D_1234_5678};
        doReset();
        for (int k = 0; k < 6; k++) begin
            applyStimulus(w[k], 0, 63);
            idle(32);
        end
        assertCount++; if (overflow_o !== 1'b1) begin failCount++; $display("[TB] FAIL b2b_overflow: got %b expected 1", overflow_o); end
        assertCount++; if (overflow_cnt_o !== (CNT_EN ? 8'd2 : 8'd0)) begin failCount++; $display("[TB] FAIL b2b_ovf_cnt: got %0d expected %0d", overflow_cnt_o, CNT_EN ? 2 : 0); end
        for (int k = 0; k < 4; k++) begin
            assertCount++; if (valid_o !== 1'b1) begin failCount++; $display("[TB] FAIL b2b_valid%0d: got %b expected 1", k, valid_o); end
            assertCount++; if (data_o !== w[k]) begin failCount++; $display("[TB] FAIL b2b_data%0d: got %h expected %h", k, data_o, w[k]); end
            ready_i = 1'b1;
            idle(1);
            ready_i = 1'b0;
        end
        assertCount++; if (valid_o !== 1'b0) begin failCount++; $display("[TB] FAIL b2b_drained: got %b expected 0", valid_o); end
    endtask

    task automatic test_pop_on_full();
        logic [63:0] w [5];
        w = '{64'h0000_0000_0000_00A1, 64'h0000_0000_0000_00B2, 64'h0000_0000_0000_00C3,
              64'h0000_0000_0000_00D4, 64'hF0F0_F0F0_0F0F_0F0F};
        doReset();
        for (int k = 0; k < 4; k++) begin
            applyStimulus(w[k], 0, 63);
            idle(32);
        end
        applyStimulus(w[4], 0, 62);
        @(negedge clk_800MHz);
        clkValid_i = 1'b1;
        dataPin_i  = w[4][63];
        ready_i    = 1'b1;
        idle(1);
        ready_i = 1'b0;
        assertCount++; if (overflow_o !== 1'b0) begin failCount++; $display("[TB] FAIL popfull_overflow: got %b expected 0", overflow_o); end
        assertCount++; if (overflow_cnt_o !== 8'd0) begin failCount++; $display("[TB] FAIL popfull_ovf_cnt: got %0d expected 0", overflow_cnt_o); end
        for (int k = 1; k < 5; k++) begin
            assertCount++; if (data_o !== w[k] || valid_o !== 1'b1) begin failCount++; $display("[TB] FAIL popfull_data%0d: got %h/%b expected %h/1", k, data_o, valid_o, w[k]); end
            ready_i = 1'b1;
            idle(1);
            ready_i = 1'b0;
        end
        assertCount++; if (valid_o !== 1'b0) begin failCount++; $display("[TB] FAIL popfull_drained: got %b expected 0", valid_o); end
    endtask

    task automatic test_early_drop();
        logic [63:0] a, b;
        a = 64'h7777_6666_5555_4444;
        b = 64'h1357_9BDF_2468_ACE0;
        doReset();
        applyStimulus(a, 0, 39);
        idle(1);
        idle(1);
        assertCount++; if (frame_err_o !== 1'b1) begin failCount++; $display("[TB] FAIL drop_err_pulse: got %b expected 1", frame_err_o); end
        idle(1);
        assertCount++; if (frame_err_o !== 1'b0) begin failCount++; $display("[TB] FAIL drop_err_width: got %b expected 0", frame_err_o); end
        assertCount++; if (valid_o !== 1'b0) begin failCount++; $display("[TB] FAIL drop_no_push: got %b expected 0", valid_o); end
        // The offending sample starts RESYNC at zero, so 32 more idle cycles follow it.
        idle(30);
        applyStimulus(b, 0, 63);
        idle(1);
        assertCount++; if (valid_o !== 1'b1 || data_o !== b) begin failCount++; $display("[TB] FAIL drop_next_frame: got %h/%b expected %h/1", data_o, valid_o, b); end
        assertCount++; if (frame_err_cnt_o !== (CNT_EN ? 8'd1 : 8'd0)) begin failCount++; $display("[TB] FAIL drop_err_cnt: got %0d expected %0d", frame_err_cnt_o, CNT_EN ? 1 : 0); end
        ready_i = 1'b1;
        idle(1);
        ready_i = 1'b0;
        assertCount++; if (valid_o !== 1'b0) begin failCount++; $display("[TB] FAIL drop_single_word: got %b expected 0", valid_o); end
    endtask

    task automatic test_short_gap();
        logic [63:0] a, c, d;
        a = 64'hA5A5_A5A5_0000_FFFF;
        c = 64'h3C3C_3C3C_3C3C_3C3D;
        d = 64'h0F1E_2D3C_4B5A_6978;
        doReset();
        applyStimulus(a, 0, 63);
        idle(20);
        applyStimulus(c, 0, 1);
        assertCount++; if (frame_err_o !== 1'b1) begin failCount++; $display("[TB] FAIL gap_err_pulse: got %b expected 1", frame_err_o); end
        applyStimulus(c, 2, 2);
        assertCount++; if (frame_err_o !== 1'b0) begin failCount++; $display("[TB] FAIL gap_err_width: got %b expected 0", frame_err_o); end
        applyStimulus(c, 3, 63);
        idle(32);
        applyStimulus(d, 0, 63);
        idle(1);
        assertCount++; if (data_o !== a || valid_o !== 1'b1) begin failCount++; $display("[TB] FAIL gap_first_word: got %h/%b expected %h/1", data_o, valid_o, a); end
        assertCount++; if (frame_err_cnt_o !== (CNT_EN ? 8'd1 : 8'd0)) begin failCount++; $display("[TB] FAIL gap_err_cnt: got %0d expected %0d", frame_err_cnt_o, CNT_EN ? 1 : 0); end
        ready_i = 1'b1;
        idle(1);
        ready_i = 1'b0;
        assertCount++; if (data_o !== d || valid_o !== 1'b1) begin failCount++; $display("[TB] FAIL gap_second_word: got %h/%b expected %h/1", data_o, valid_o, d); end
        ready_i = 1'b1;
        idle(1);
        ready_i = 1'b0;
        assertCount++; if (valid_o !== 1'b0) begin failCount++; $display("[TB] FAIL gap_drained: got %b expected 0", valid_o); end
    endtask

    task automatic test_enable_low();
        logic [63:0] a, b;
        a = 64'h9999_8888_7777_6666;
        b = 64'h0000_FFFF_1234_4321;
        doReset();
        enable_i = 1'b0;
        applyStimulus(a, 0, 63);
        idle(2);
        assertCount++; if (valid_o !== 1'b0) begin failCount++; $display("[TB] FAIL en_no_push: got %b expected 0", valid_o); end
        assertCount++; if (overflow_o !== 1'b0) begin failCount++; $display("[TB] FAIL en_no_overflow: got %b expected 0", overflow_o); end
        enable_i = 1'b1;
        idle(30);
        applyStimulus(b, 0, 63);
        idle(1);
        assertCount++; if (valid_o !== 1'b1 || data_o !== b) begin failCount++; $display("[TB] FAIL en_next_frame: got %h/%b expected %h/1", data_o, valid_o, b); end
    endtask

    task automatic test_mid_frame_reset();
        logic [63:0] a, b;
        a = 64'h5A5A_5A5A_5A5A_5A5A;
        b = 64'hFEDC_BA98_7654_3210;
        doReset();
        applyStimulus(a, 0, 63);
        idle(32);
        applyStimulus(b, 0, 29);
        @(negedge clk_800MHz);
        clkValid_i = 1'b1;
        dataPin_i  = b[30];
        reset_n    = 1'b0;
        @(negedge clk_800MHz);
        reset_n    = 1'b1;
        clkValid_i = 1'b0;
        assertCount++; if (valid_o !== 1'b0) begin failCount++; $display("[TB] FAIL rst_mid_valid: got %b expected 0", valid_o); end
        assertCount++; if (data_o !== 64'd0) begin failCount++; $display("[TB] FAIL rst_mid_data: got %h expected 0", data_o); end
        assertCount++; if (overflow_o !== 1'b0 || frame_err_o !== 1'b0) begin failCount++; $display("[TB] FAIL rst_mid_flags: got %b%b expected 00", overflow_o, frame_err_o); end
        idle(32);
        applyStimulus(b, 0, 63);
        idle(1);
        assertCount++; if (valid_o !== 1'b1 || data_o !== b) begin failCount++; $display("[TB] FAIL rst_mid_restart: got %h/%b expected %h/1", data_o, valid_o, b); end
        assertCount++; if (frame_err_o !== 1'b0) begin failCount++; $display("[TB] FAIL rst_mid_no_err: got %b expected 0", frame_err_o); end
    endtask

    initial begin
        $display("[TB] sb_rx_deser directed test start (counters %s)", CNT_EN ? "on" : "off");
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_pop_on_full();
        test_early_drop();
        test_short_gap();
        test_enable_low();
        test_mid_frame_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
